// File: rtl/mem_boot_loader.sv
// rtl/mem_boot_loader.sv - framed byte-stream loader that fills test memory and releases the core
module mem_boot_loader #(
    parameter int ADDR_W        = 16,
    parameter int RELEASE_DELAY = 4
) (
    input  logic              ph1,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_resetb,
    output logic              done,
    output logic              error
);

    typedef enum logic [3:0] {
        S_ADDR_LO,
        S_ADDR_HI,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_WAIT,
        S_RUN,
        S_ERR
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              accept_state;
    logic              xfer;
    logic [7:0]        addr_lo;
    logic [7:0]        len_lo;
    logic [ADDR_W-1:0] ptr;
    logic [15:0]       remaining;
    logic [7:0]        sum;
    logic [7:0]        cnt;

    // Only the frame-parsing states take bytes; reset forces ready low immediately.
    assign in_ready = !reset && accept_state;
    assign xfer     = in_valid && in_ready;

    // State register.
    always_ff @(posedge ph1) begin
        if (reset) begin
            state <= S_ADDR_LO;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the ready qualifier for each state.
    always_comb begin
        next_state   = state;
        accept_state = 1'b0;
        case (state)
            S_ADDR_LO: begin
                accept_state = 1'b1;
                if (xfer) next_state = S_ADDR_HI;
            end
            S_ADDR_HI: begin
                accept_state = 1'b1;
                if (xfer) next_state = S_LEN_LO;
            end
            S_LEN_LO: begin
                accept_state = 1'b1;
                if (xfer) next_state = S_LEN_HI;
            end
            S_LEN_HI: begin
                accept_state = 1'b1;
                // A zero-length frame carries only the checksum byte.
                if (xfer) next_state = ({in_data, len_lo} == 16'd0) ? S_CSUM : S_DATA;
            end
            S_DATA: begin
                accept_state = 1'b1;
                if (xfer && remaining == 16'd1) next_state = S_CSUM;
            end
            S_CSUM: begin
                accept_state = 1'b1;
                if (xfer) next_state = (in_data == sum) ? S_WAIT : S_ERR;
            end
            S_WAIT: begin
                if (cnt == 8'd0) next_state = S_RUN;
            end
            S_RUN:   next_state = S_RUN;
            S_ERR:   next_state = S_ERR;
            default: next_state = S_ADDR_LO;
        endcase
    end

    // Header capture, payload write pipeline, checksum accumulation and release counter.
    always_ff @(posedge ph1) begin
        if (reset) begin
            addr_lo    <= 8'd0;
            len_lo     <= 8'd0;
            ptr        <= '0;
            remaining  <= 16'd0;
            sum        <= 8'd0;
            cnt        <= 8'd0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'd0;
            cpu_resetb <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_ADDR_LO: if (xfer) addr_lo <= in_data;
                S_ADDR_HI: if (xfer) ptr <= ADDR_W'({in_data, addr_lo});
                S_LEN_LO:  if (xfer) len_lo <= in_data;
                S_LEN_HI:  if (xfer) remaining <= {in_data, len_lo};
                S_DATA: begin
                    if (xfer) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= in_data;
                        ptr       <= ptr + ADDR_W'(1);
                        sum       <= sum + in_data;
                        remaining <= remaining - 16'd1;
                    end
                end
                S_CSUM:  if (xfer) cnt <= 8'(RELEASE_DELAY);
                S_WAIT:  if (cnt != 8'd0) cnt <= cnt - 8'd1;
                default: ;
            endcase
            // Registered from the next state so release and error are glitch-free.
            cpu_resetb <= (next_state == S_RUN);
            done       <= (next_state == S_RUN);
            error      <= (next_state == S_ERR);
        end
    end

endmodule

// File: tb/tb_mem_boot_loader.sv
// tb/tb_mem_boot_loader.sv - directed table-driven bench for mem_boot_loader
module tb_mem_boot_loader;

    logic        ph1 = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_resetb;
    logic        done;
    logic        error;

    mem_boot_loader #(.ADDR_W(16), .RELEASE_DELAY(4)) dut (
        .ph1        (ph1),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_resetb (cpu_resetb),
        .done       (done),
        .error      (error)
    );

    always #5 ph1 = ~ph1;

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;
    int csum_cyc = 0;
    int rise_cyc = 0;
    bit rise_seen = 1'b0;
    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];

    always @(posedge ph1) cyc <= cyc + 1;

    always @(negedge ph1) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
        if (cpu_resetb && !rise_seen) begin
            rise_seen = 1'b1;
            rise_cyc  = cyc;
        end
    end

    typedef struct {
        string       name;
        logic [63:0] frame;
        int          nbytes;
        bit          gaps;
        int          nwr;
        logic [63:0] waddr;
        logic [31:0] wdata;
        bit          exp_err;
        bit          exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit full);
        @(negedge ph1);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge ph1);
        @(negedge ph1);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_cpu_resetb", {31'd0, cpu_resetb}, 32'd0);
        chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
        if (full) begin
            chk("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
            chk("reset_mem_wdata", {24'd0, mem_wdata}, 32'd0);
            chk("reset_done_error", {30'd0, done, error}, 32'd0);
        end
        reset = 1'b0;
        wa_q.delete();
        wd_q.delete();
        rise_seen = 1'b0;
        @(negedge ph1);
        if (full) chk("ready_after_reset", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int tries;
        for (int g = 0; g < gap; g++) begin
            @(negedge ph1);
            in_valid = 1'b0;
        end
        @(negedge ph1);
        in_valid = 1'b1;
        in_data  = b;
        tries = 0;
        while (!in_ready && tries < 20) begin
            @(negedge ph1);
            tries++;
        end
        if (!in_ready) begin
            ncmp++;
            nfail++;
            $display("FAIL send_timeout: in_ready stuck 0 for byte %0h", b);
        end else begin
            @(posedge ph1);
            #1;
            csum_cyc = cyc;
        end
    endtask

    task automatic send_frame(input logic [63:0] fr, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = fr[63 - 8*i -: 8];
            send(b, gaps ? int'($urandom_range(0, 3)) : 0);
        end
        @(negedge ph1);
        in_valid = 1'b0;
    endtask

    task automatic check_writes(input string name, input int nwr, input logic [63:0] wa,
                                input logic [31:0] wd);
        chk({name, "_wr_count"}, wa_q.size(), nwr);
        for (int i = 0; i < nwr && i < wa_q.size(); i++) begin
            chk({name, "_wr_addr"}, {16'd0, wa_q[i]}, {16'd0, wa[63 - 16*i -: 16]});
            chk({name, "_wr_data"}, {24'd0, wd_q[i]}, {24'd0, wd[31 - 8*i -: 8]});
        end
    endtask

    initial begin
        vecs[0] = '{"vector", 64'hFC0F020000F0F000, 7, 1'b0, 2,
                    64'h0FFC0FFD00000000, 32'h00F00000, 1'b0, 1'b1};
        vecs[1] = '{"throttle", 64'hFC0F020000F0F000, 7, 1'b1, 2,
                    64'h0FFC0FFD00000000, 32'h00F00000, 1'b0, 1'b1};
        vecs[2] = '{"badsum", 64'h00000100A5000000, 6, 1'b0, 1,
                    64'h0000000000000000, 32'hA5000000, 1'b1, 1'b0};
        vecs[3] = '{"zerolen", 64'h0010000000000000, 5, 1'b0, 0,
                    64'h0, 32'h0, 1'b0, 1'b1};
        vecs[4] = '{"zerolen_bad", 64'h0010000001000000, 5, 1'b0, 0,
                    64'h0, 32'h0, 1'b1, 1'b0};
        vecs[5] = '{"wrap", 64'hFFFF020011223300, 7, 1'b0, 2,
                    64'hFFFF000000000000, 32'h11220000, 1'b0, 1'b1};

        for (int v = 0; v < 6; v++) begin
            do_reset(v == 0);
            send_frame(vecs[v].frame, vecs[v].nbytes, vecs[v].gaps);
            repeat (12) @(negedge ph1);
            check_writes(vecs[v].name, vecs[v].nwr, vecs[v].waddr, vecs[v].wdata);
            chk({vecs[v].name, "_error"}, {31'd0, error}, {31'd0, vecs[v].exp_err});
            chk({vecs[v].name, "_done"}, {31'd0, done}, {31'd0, vecs[v].exp_done});
            chk({vecs[v].name, "_cpu_resetb"}, {31'd0, cpu_resetb}, {31'd0, vecs[v].exp_done});
            chk({vecs[v].name, "_in_ready_end"}, {31'd0, in_ready}, 32'd0);
            if (vecs[v].exp_done)
                chk({vecs[v].name, "_release_delay"}, rise_cyc - csum_cyc, 32'd5);
            if (vecs[v].nwr == 2) begin
                chk({vecs[v].name, "_addr_hold"}, {16'd0, mem_addr},
                    {16'd0, vecs[v].waddr[47:32]});
                chk({vecs[v].name, "_data_hold"}, {24'd0, mem_wdata},
                    {24'd0, vecs[v].wdata[23:16]});
            end
        end

        // Mid-frame reset: two of four payload bytes, then a clean frame.
        do_reset(1'b0);
        send(8'h00, 0); send(8'h20, 0); send(8'h04, 0); send(8'h00, 0);
        send(8'h11, 0); send(8'h22, 0);
        @(negedge ph1);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge ph1);
        @(negedge ph1);
        chk("midreset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midreset_cpu_resetb", {31'd0, cpu_resetb}, 32'd0);
        reset = 1'b0;
        rise_seen = 1'b0;
        repeat (3) @(negedge ph1);
        chk("midreset_no_extra_we", wa_q.size(), 32'd2);
        send_frame(64'h003001007E7E0000, 6, 1'b0);
        repeat (12) @(negedge ph1);
        check_writes("midreset", 3, 64'h2000200130000000, 32'h11227E00);
        chk("midreset_done", {31'd0, done}, 32'd1);
        chk("midreset_release_delay", rise_cyc - csum_cyc, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mem_boot_loader.md
Name: mem_boot_loader

Overview:
- Writer side of the test memory that the 6502 core fetches from.
- Accepts a framed byte stream from a bench or host, writes the payload into the top-level memory, and verifies a checksum.
- Holds the core in reset until loading finishes, then releases it, so ROM images reach the core over a stream interface rather than by direct array preload.
- Sits beside mem in top; its write port is muxed ahead of the CPU write port.

Parameters:
- ADDR_W, 16, memory address width in bits.
- RELEASE_DELAY, 4, ph1 cycles between checksum acceptance and cpu_resetb rising; legal range 1..255.

Ports:
- ph1  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  stream byte valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  one-cycle memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  8  write data.
- cpu_resetb  output  1  active-low reset to the core.
- done  output  1  load complete and core released.
- error  output  1  checksum mismatch; sticky until reset.

Behaviour:
- Frame format, in order:
  - ADDR_LO, ADDR_HI: start address.
  - LEN_LO, LEN_HI: payload byte count N, 0..65535.
  - N payload bytes.
  - CSUM: 8-bit modulo-256 sum of the payload bytes only.
- Handshake:
  - A byte transfers on a rising edge where in_valid && in_ready.
  - in_valid may drop at any time; an idle cycle has no effect.
  - in_data is sampled only on transfer.
- in_ready is 1 in the states ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA and CSUM. It is 0 in all other states.
- States: ADDR_LO -> ADDR_HI -> LEN_LO -> LEN_HI -> DATA -> CSUM -> WAIT -> RUN, plus ERR.
  - Each header state advances by one state per transfer.
  - LEN_HI: if the assembled N == 0, go directly to CSUM.
  - DATA: on each transfer:
    - mem_we=1 in the following cycle, with mem_addr = current pointer and mem_wdata = the byte (registered, 1-cycle latency).
    - Pointer increments and wraps 2^ADDR_W-1 -> 0.
    - Running sum adds the byte modulo 256.
    - Remaining count decrements; the transfer that brings it to 0 moves the FSM to CSUM.
  - CSUM: on transfer:
    - Byte equals running sum -> WAIT, with counter loaded to RELEASE_DELAY.
    - Otherwise -> ERR, with error=1.
  - WAIT: counter decrements each cycle; when it reaches 0, go to RUN.
  - RUN: cpu_resetb=1 and done=1. Terminal until reset; in_ready=0.
  - ERR: cpu_resetb=0, done=0, error=1. Terminal until reset; in_ready=0.
- Reset values:
  - State ADDR_LO.
  - in_ready=1 in the cycle after reset deasserts; in_ready is 0 while reset is high.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_resetb=0, done=0, error=0.
  - Running sum=0, counters=0.
- Reset asserted mid-frame:
  - Any partial frame is abandoned and no further mem_we occurs.
  - Memory bytes already written stay written.
  - The core is re-held in reset.
- mem_we is never asserted in any state other than the cycle after a DATA transfer.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- cpu_resetb is registered, so it never glitches. It rises exactly RELEASE_DELAY+1 cycles after the CSUM transfer edge.
- Payload plus header beyond the address space wraps silently; no error is raised.

Test Plan:
- Vector load: frame FC 0F 02 00 00 F0 F0 → writes [0x0FFC]=0x00, [0x0FFD]=0xF0 on consecutive strobes. cpu_resetb rises 5 cycles after the CSUM byte with RELEASE_DELAY=4, and done=1.
- Bad checksum: frame 00 00 01 00 A5 00 → one write [0x0000]=0xA5, then error=1. cpu_resetb stays 0 and in_ready=0 thereafter.
- Zero length: frame 00 10 00 00 00 → no mem_we, and done asserts after the delay. Checksum 0x01 instead → error=1.
- Wrap: frame FF FF 02 00 11 22 33 → writes [0xFFFF]=0x11 then [0x0000]=0x22, checksum passes.
- Throttling: insert random in_valid gaps of 0..3 cycles through the vector-load frame → identical writes and release timing relative to the CSUM transfer.
- Mid-frame reset: assert reset after 2 of 4 payload bytes, then send a full valid frame → only the first 2 bytes of the aborted frame are written; the new frame loads normally and done=1.
- End-to-end with the core: load a program that stores 0xA5 to RAM[66] → after done, the core runs and RAM[66]=0xA5 within 2000 ns.
